// File: rtl/ysyx_25040111_ifu_pkg.sv
// Shared IFU definitions: FSM state encoding, instruction width and the default reset PC.
// Imported by the IFU top and its testbench.
package ysyx_25040111_ifu_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10,
        S_NEXT = 2'b11
    } ifu_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25040111_Reg.sv
// Width/reset-value parameterised register with synchronous active-high reset and load enable.
module ysyx_25040111_Reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_25040111_ifu.sv
// Single-issue instruction fetch unit: one fetch per committed instruction, flushed by redirect.
// Optional alignment check enabled by defining YSYX_25040111_IFU_MISALIGN_CHK_EN (adds port misalign).
module ysyx_25040111_ifu
    import ysyx_25040111_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       out_pc
`ifdef YSYX_25040111_IFU_MISALIGN_CHK_EN
    ,
    output logic              misalign
`endif
);

    ifu_state_e        state_reg, state_next;
    logic              kill_reg, kill_next;
    logic [31:0]       pc_reg;
    logic [INST_W-1:0] inst_reg;
    logic              inst_en;
    logic              req_ok;

    // The PC only ever changes on a redirect; there is no sequential PC arithmetic here.
    ysyx_25040111_Reg #(
        .WIDTH     (32),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (redirect_valid),
        .d   (redirect_pc),
        .q   (pc_reg)
    );

    ysyx_25040111_Reg #(
        .WIDTH     (INST_W),
        .RESET_VAL ('0)
    ) u_inst_reg (
        .clk (clk),
        .rst (rst),
        .en  (inst_en),
        .d   (mem_rsp_data),
        .q   (inst_reg)
    );

`ifdef YSYX_25040111_IFU_MISALIGN_CHK_EN
    logic misalign_reg;

    assign req_ok = is_word_aligned(pc_reg);

    // Sticky until the next redirect so software sees which target faulted.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else if (redirect_valid) begin
            misalign_reg <= 1'b0;
        end else if (state_reg == S_REQ && !req_ok) begin
            misalign_reg <= 1'b1;
        end
    end

    assign misalign = misalign_reg;
`else
    assign req_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_REQ;
            kill_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            kill_reg  <= kill_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        kill_next  = kill_reg;
        unique case (state_reg)
            S_REQ: begin
                if (!req_ok) begin
                    if (!redirect_valid) begin
                        state_next = S_NEXT;
                    end
                end else if (mem_req_ready) begin
                    // A redirect in the accept cycle leaves the old address in flight.
                    state_next = S_WAIT;
                    kill_next  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    kill_next  = 1'b0;
                    state_next = (kill_reg || redirect_valid) ? S_REQ : S_HOLD;
                end else if (redirect_valid) begin
                    kill_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_next = S_REQ;
                end else if (out_ready) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (redirect_valid) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
                kill_next  = 1'b0;
            end
        endcase
    end

    assign inst_en = (state_reg == S_WAIT) && mem_rsp_valid && !kill_reg && !redirect_valid;

    assign mem_req_valid = (state_reg == S_REQ) && req_ok && !rst;
    assign out_valid     = (state_reg == S_HOLD) && !rst;
    assign mem_addr      = pc_reg;
    assign out_pc        = pc_reg;
    assign out_inst      = inst_reg;

endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// Testbench for ysyx_25040111_ifu: directed vector table, flush corner cases, randomized
// run against a transaction-level model of fetch epochs and a simple memory responder.
module tb_ysyx_25040111_ifu;
    import ysyx_25040111_ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef YSYX_25040111_IFU_MISALIGN_CHK_EN
    logic        misalign;
`endif

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    ysyx_25040111_ifu #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef YSYX_25040111_IFU_MISALIGN_CHK_EN
        ,
        .misalign       (misalign)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          req_stall;
        int          rsp_delay;
        int          hold;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
    endtask

    task automatic do_accept();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic do_respond(input logic [31:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
    endtask

    task automatic do_handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // One complete fetch transaction driven from a table entry.
    task automatic do_txn(input vec_t v, input bit with_redirect);
        if (with_redirect) begin
            chk("idle_no_req", 32'(mem_req_valid), 32'd0);
            do_redirect(v.pc);
        end
        chk("req_valid", 32'(mem_req_valid), 32'd1);
        chk("req_addr", mem_addr, v.pc);
        for (int i = 0; i < v.req_stall; i++) begin
            tick();
            chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
            chk("stall_req_addr", mem_addr, v.pc);
        end
        do_accept();
        chk("req_dropped_after_accept", 32'(mem_req_valid), 32'd0);
        for (int i = 0; i < v.rsp_delay; i++) begin
            tick();
            chk("wait_no_out", 32'(out_valid), 32'd0);
        end
        do_respond(v.inst);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_inst", out_inst, v.inst);
        chk("out_pc", out_pc, v.pc);
        for (int i = 0; i < v.hold; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_inst", out_inst, v.inst);
            chk("hold_pc", out_pc, v.pc);
        end
        do_handshake();
        chk("after_hs_out", 32'(out_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("next_no_req", 32'(mem_req_valid), 32'd0);
        end
        $display("[TB] txn pc=%h inst=%h stall=%0d delay=%0d hold=%0d", v.pc, v.inst,
                 v.req_stall, v.rsp_delay, v.hold);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          out_cnt;
        logic [31:0] exp_pc;
        bit          delivered;
        bit          awaiting;
        int          wait_cnt;
        int          since_red;
        int          deliveries;
        bit          busy;
        int          cnt;
        logic [31:0] addr_q;
        bit          rsp_now;
        bit          red;
        logic [31:0] new_pc;

        vecs[0] = '{pc: 32'h8000_0000, inst: 32'h0010_0093, req_stall: 0, rsp_delay: 0, hold: 5};
        vecs[1] = '{pc: 32'h8000_0004, inst: 32'h0020_8113, req_stall: 3, rsp_delay: 4, hold: 0};
        vecs[2] = '{pc: 32'h8000_0008, inst: 32'hFFF0_0F93, req_stall: 1, rsp_delay: 2, hold: 1};
        vecs[3] = '{pc: 32'h8000_0FFC, inst: 32'h8000_0537, req_stall: 0, rsp_delay: 1, hold: 2};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        out_ready      = 1'b0;

        // Reset for two cycles; outputs gated while rst is high.
        @(negedge clk);
        chk("rst_req_gated", 32'(mem_req_valid), 32'd0);
        chk("rst_out_gated", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("reset_addr", mem_addr, RST_PC);
        chk("reset_inst", out_inst, 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);

        do_txn(vecs[0], 1'b0);
        for (int i = 1; i < 4; i++) do_txn(vecs[i], 1'b1);

        // A response outside S_WAIT must be ignored.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        mem_rsp_valid = 1'b0;
        chk("stray_rsp_no_out", 32'(out_valid), 32'd0);
        chk("stray_rsp_no_req", 32'(mem_req_valid), 32'd0);

        // Redirect while waiting: response dropped, refetch at new target, single delivery.
        do_redirect(32'h8000_0010);
        do_accept();
        do_redirect(32'h8000_0100);
        chk("wflush_no_req", 32'(mem_req_valid), 32'd0);
        do_respond(32'hDEAD_BEEF);
        chk("wflush_dropped", 32'(out_valid), 32'd0);
        chk("wflush_refetch", 32'(mem_req_valid), 32'd1);
        chk("wflush_addr", mem_addr, 32'h8000_0100);
        do_accept();
        do_respond(32'h0050_0113);
        chk("wflush_out_inst", out_inst, 32'h0050_0113);
        chk("wflush_out_pc", out_pc, 32'h8000_0100);
        do_handshake();
        out_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) out_cnt++;
        end
        chk("wflush_single_out", 32'(out_cnt), 32'd0);
        $display("[TB] txn flush-in-wait pc=80000100");

        // Redirect together with out_ready in S_HOLD: handshake is discarded.
        do_redirect(32'h8000_0040);
        do_accept();
        do_respond(32'h1111_1111);
        chk("hflush_hold", 32'(out_valid), 32'd1);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        chk("hflush_out_dropped", 32'(out_valid), 32'd0);
        chk("hflush_req", 32'(mem_req_valid), 32'd1);
        chk("hflush_addr", mem_addr, 32'h8000_0100);
        do_accept();
        do_respond(32'h00A0_0193);
        chk("hflush_out_inst", out_inst, 32'h00A0_0193);
        chk("hflush_out_pc", out_pc, 32'h8000_0100);
        do_handshake();
        $display("[TB] txn flush-in-hold pc=80000100");

        // Redirect in S_REQ on the accept cycle, then a redirect while stalled.
        do_redirect(32'h8000_0020);
        chk("rflush_addr0", mem_addr, 32'h8000_0020);
        mem_req_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b0;
        chk("rflush_kill_wait", 32'(mem_req_valid), 32'd0);
        do_respond(32'hCAFE_F00D);
        chk("rflush_dropped", 32'(out_valid), 32'd0);
        chk("rflush_addr1", mem_addr, 32'h8000_0200);
        do_redirect(32'h8000_0300);
        chk("rflush_stall_req", 32'(mem_req_valid), 32'd1);
        chk("rflush_addr2", mem_addr, 32'h8000_0300);
        do_accept();
        do_respond(32'h0000_0073);
        chk("rflush_out_pc", out_pc, 32'h8000_0300);
        chk("rflush_out_inst", out_inst, 32'h0000_0073);
        do_handshake();
        $display("[TB] txn flush-in-req pc=80000300");

`ifdef YSYX_25040111_IFU_MISALIGN_CHK_EN
        do_redirect(32'h8000_0002);
        chk("mis_no_req0", 32'(mem_req_valid), 32'd0);
        tick();
        chk("mis_no_req1", 32'(mem_req_valid), 32'd0);
        chk("mis_flag", 32'(misalign), 32'd1);
        tick();
        chk("mis_sticky", 32'(misalign), 32'd1);
        do_redirect(32'h8000_0008);
        chk("mis_cleared", 32'(misalign), 32'd0);
        chk("mis_req", 32'(mem_req_valid), 32'd1);
        chk("mis_addr", mem_addr, 32'h8000_0008);
        do_accept();
        do_respond(32'h0010_0093);
        chk("mis_out_pc", out_pc, 32'h8000_0008);
        do_handshake();
        $display("[TB] txn misalign pc=80000002 then 80000008");
`endif

        // Reset while a fetch is outstanding.
        do_redirect(32'h8000_0400);
        do_accept();
        rst = 1'b1;
        tick();
        chk("midrst_req_gated", 32'(mem_req_valid), 32'd0);
        chk("midrst_out_gated", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req_valid), 32'd1);
        chk("midrst_addr", mem_addr, RST_PC);
        chk("midrst_inst", out_inst, 32'd0);
        $display("[TB] txn reset-mid-fetch");

        // Randomized run: each redirect opens an epoch that must deliver {mem_word(pc), pc} at most once.
        exp_pc     = RST_PC;
        delivered  = 1'b0;
        awaiting   = 1'b0;
        wait_cnt   = 0;
        since_red  = 0;
        deliveries = 0;
        busy       = 1'b0;
        cnt        = 0;
        addr_q     = '0;
        for (int c = 0; c < 3000; c++) begin
            if (awaiting && wait_cnt > 0) wait_cnt--;
            rsp_now       = busy && (cnt == 0);
            mem_rsp_valid = rsp_now;
            mem_rsp_data  = rsp_now ? mem_word(addr_q) : $urandom;
            mem_req_ready = 1'($urandom_range(0, 1));
            out_ready     = 1'($urandom_range(0, 1));
            red           = (awaiting && wait_cnt == 0) || ($urandom_range(0, 19) == 0);
            new_pc        = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            redirect_valid = red;
            redirect_pc    = red ? new_pc : $urandom;
            #1;

            if (mem_req_valid && mem_req_ready) begin
                chk("rnd_req_addr", mem_addr, exp_pc);
                chk("rnd_one_outstanding", 32'(busy), 32'd0);
            end
            if (out_valid && out_ready && !red) begin
                chk("rnd_out_pc", out_pc, exp_pc);
                chk("rnd_out_inst", out_inst, mem_word(exp_pc));
                chk("rnd_once_per_redirect", 32'(delivered), 32'd0);
                $display("[TB] rnd deliver pc=%h inst=%h", out_pc, out_inst);
                delivered = 1'b1;
                deliveries++;
                awaiting  = 1'b1;
                wait_cnt  = $urandom_range(0, 4);
            end
            if (red) begin
                exp_pc    = new_pc;
                delivered = 1'b0;
                awaiting  = 1'b0;
                since_red = 0;
            end else begin
                since_red++;
                if (since_red > 200 && !delivered) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL rnd_timeout: no delivery for pc %h within 200 cycles", exp_pc);
                    since_red = 0;
                end
            end

            if (mem_req_valid && mem_req_ready) begin
                busy   = 1'b1;
                addr_q = mem_addr;
                cnt    = $urandom_range(0, 3);
            end else if (rsp_now) begin
                busy = 1'b0;
            end else if (busy && cnt > 0) begin
                cnt--;
            end
            tick();
        end
        redirect_valid = 1'b0;
        mem_rsp_valid  = 1'b0;
        chk("rnd_some_deliveries", 32'(deliveries > 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
